// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter with a registered one-hot grant and a forced idle gap after each ack.
// Define ARB_TIMEOUT_EN to build the grant watchdog (timeout_err); otherwise timeout_err is tied low.
package arb_pkg;
    localparam int unsigned ARB_WIDTH = 4;
    typedef logic [ARB_WIDTH-1:0] arb_vector;
    localparam arb_vector NO_GRANT = '0;
endpackage

module bus_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         bus_req,
    input  logic                     bus_ack,
    output arb_pkg::arb_vector       bus_grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout_err
);
    import arb_pkg::*;

    localparam int unsigned ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] idx;
    logic            found;
    arb_vector       onehot;

    if (N_REQ != ARB_WIDTH || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("bus_arbiter: N_REQ must equal the arb_vector width and TIMEOUT_CYC must be at least 2");
    end

    // Scan upward from last+1 with wrap; the first active request wins.
    always_comb begin
        winner = last;
        idx    = '0;
        found  = 1'b0;
        onehot = NO_GRANT;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = ID_W'((32'(last) + i) % N_REQ);
            if (!found && bus_req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        onehot[winner] = 1'b1;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned AGE_W = $clog2(TIMEOUT_CYC);
    logic [AGE_W-1:0] age;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bus_grant <= NO_GRANT;
            grant_id  <= '0;
            busy      <= 1'b0;
            last      <= ID_W'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            age         <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|bus_req) begin
                        state     <= GRANT;
                        bus_grant <= onehot;
                        grant_id  <= winner;
                        busy      <= 1'b1;
                        last      <= winner;
`ifdef ARB_TIMEOUT_EN
                        age       <= '0;
`endif
                    end
                end
                GRANT: begin
                    // Ack is checked first so a coincident expiry never raises timeout_err.
                    if (bus_ack) begin
                        state     <= GAP;
                        bus_grant <= NO_GRANT;
                        busy      <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (age == AGE_W'(TIMEOUT_CYC - 1)) begin
                        state       <= GAP;
                        bus_grant   <= NO_GRANT;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        age <= age + 1'b1;
                    end
`endif
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    bus_grant <= NO_GRANT;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized stress against a behavioural model.
module tb_bus_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         bus_req;
    logic               bus_ack;
    arb_pkg::arb_vector bus_grant;
    logic [1:0]         grant_id;
    logic               busy;
    logic               timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, how long they have held it, whether the idle gap is pending.
    bit m_busy, m_gap, m_tmo;
    int m_owner, m_last, m_held;

    bus_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_ack(bus_ack),
        .bus_grant(bus_grant), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(logic [3:0] req, int last);
        int k;
        for (int d = 1; d <= N; d++) begin
            k = (last + d) % N;
            if (req[k[1:0]]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gap = 0; m_tmo = 0; m_owner = 0; m_last = N - 1; m_held = 0;
    endtask

    task automatic model_edge(input logic [3:0] req, input logic ack);
        m_tmo = 0;
        if (m_busy) begin
            if (ack) begin
                m_busy = 0; m_gap = 1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_held == TMO) begin
                m_busy = 0; m_gap = 1; m_tmo = 1;
            end
`endif
            else m_held++;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (req != 4'b0000) begin
            m_owner = rr_pick(req, m_last);
            m_last  = m_owner;
            m_busy  = 1;
            m_held  = 1;
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are observed at the same point.
    task automatic cycle(input logic [3:0] req, input logic ack);
        bus_req = req;
        bus_ack = ack;
        @(posedge clk);
        model_edge(req, ack);
        #1;
    endtask

    task automatic do_reset();
        bus_req = '0; bus_ack = 1'b0;
        reset = 1'b1; #3; reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0; bus_req = '0; bus_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; #2;
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", bus_grant); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b expected 0", timeout_err); end
        bus_req = 4'b1111;
        @(posedge clk); #1;
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL reset_held_grant: got %b expected 0000", bus_grant); end
        bus_req = '0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        cycle(4'b0010, 1'b0);
        checks++; if (bus_grant !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b expected 0010", bus_grant); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_id: got %0d expected 1", grant_id); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        cycle(4'b0010, 1'b0);
        checks++; if (bus_grant !== 4'b0010) begin errors++; $display("FAIL single_wait: got %b expected 0010", bus_grant); end
        cycle(4'b0010, 1'b1);
        checks++; if (bus_grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got %b/%b expected 0000/0", bus_grant, busy); end
        cycle(4'b0010, 1'b0);
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL single_gap: got %b expected 0000", bus_grant); end
        cycle(4'b0010, 1'b0);
        checks++; if (bus_grant !== 4'b0010 || grant_id !== 2'd1) begin errors++; $display("FAIL single_regrant: got %b/%0d expected 0010/1", bus_grant, grant_id); end
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            exp_g = 4'b0001 << (k % 4);
            cycle(4'b1111, 1'b0);
            checks++; if (bus_grant !== exp_g || grant_id !== 2'(k % 4)) begin errors++; $display("FAIL rr_grant[%0d]: got %b/%0d expected %b/%0d", k, bus_grant, grant_id, exp_g, k % 4); end
            cycle(4'b1111, 1'b1);
            checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL rr_release[%0d]: got %b expected 0000", k, bus_grant); end
            cycle(4'b1111, 1'b0);
            checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL rr_gap[%0d]: got %b expected 0000", k, bus_grant); end
        end
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_hold_drop();
        do_reset();
        cycle(4'b0100, 1'b0);
        checks++; if (bus_grant !== 4'b0100 || grant_id !== 2'd2) begin errors++; $display("FAIL hold_grant: got %b/%0d expected 0100/2", bus_grant, grant_id); end
        cycle(4'b0000, 1'b0);
        checks++; if (bus_grant !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL hold_dropped_req: got %b/%b expected 0100/1", bus_grant, busy); end
        cycle(4'b0000, 1'b1);
        checks++; if (bus_grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL hold_release: got %b/%b expected 0000/0", bus_grant, busy); end
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL hold_idle: got %b expected 0000", bus_grant); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        cycle(4'b0100, 1'b0);
        checks++; if (bus_grant !== 4'b0100) begin errors++; $display("FAIL midrst_pre: got %b expected 0100", bus_grant); end
        reset = 1'b1; #1;
        checks++; if (bus_grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL midrst_async: got %b/%b expected 0000/0", bus_grant, busy); end
        #1; reset = 1'b0;
        model_reset();
        cycle(4'b0101, 1'b0);
        checks++; if (bus_grant !== 4'b0001 || grant_id !== 2'd0) begin errors++; $display("FAIL midrst_first: got %b/%0d expected 0001/0", bus_grant, grant_id); end
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_spurious_ack();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(4'b0000, 1'b1);
            checks++; if (bus_grant !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL spurious_ack[%0d]: got %b/%b/%b expected 0000/0/0", k, bus_grant, busy, timeout_err); end
        end
        cycle(4'b1001, 1'b0);
        checks++; if (bus_grant !== 4'b0001 || grant_id !== 2'd0) begin errors++; $display("FAIL spurious_after: got %b/%0d expected 0001/0", bus_grant, grant_id); end
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_no_ack();
        do_reset();
        cycle(4'b0011, 1'b0);
        checks++; if (bus_grant !== 4'b0001) begin errors++; $display("FAIL noack_grant: got %b expected 0001", bus_grant); end
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < TMO; k++) begin
            cycle(4'b0011, 1'b0);
            checks++; if (bus_grant !== 4'b0001 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_hold[%0d]: got %b/%b expected 0001/0", k, bus_grant, timeout_err); end
        end
        cycle(4'b0011, 1'b0);
        checks++; if (bus_grant !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_expire: got %b/%b/%b expected 0000/0/1", bus_grant, busy, timeout_err); end
        cycle(4'b0011, 1'b0);
        checks++; if (bus_grant !== 4'b0000 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse_end: got %b/%b expected 0000/0", bus_grant, timeout_err); end
        cycle(4'b0011, 1'b0);
        checks++; if (bus_grant !== 4'b0010 || grant_id !== 2'd1) begin errors++; $display("FAIL tmo_next: got %b/%0d expected 0010/1", bus_grant, grant_id); end
`else
        for (int k = 0; k < 40; k++) begin
            cycle(4'b0011, 1'b0);
            checks++; if (bus_grant !== 4'b0001 || timeout_err !== 1'b0) begin errors++; $display("FAIL noack_hold[%0d]: got %b/%b expected 0001/0", k, bus_grant, timeout_err); end
        end
`endif
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] req, exp_g, h1, h2;
        logic       ack;
        do_reset();
        req = '0; h1 = '0; h2 = '0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b1; #1; reset = 1'b0;
                model_reset();
                h1 = '0; h2 = '0;
            end
            cycle(req, ack);
            exp_g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
            checks++; if (bus_grant !== exp_g) begin errors++; $display("FAIL rand_grant[%0d]: got %b expected %b", k, bus_grant, exp_g); end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy[%0d]: got %b expected %b", k, busy, m_busy); end
            if (m_busy) begin
                checks++; if (grant_id !== 2'(m_owner)) begin errors++; $display("FAIL rand_id[%0d]: got %0d expected %0d", k, grant_id, m_owner); end
            end
            checks++; if (timeout_err !== m_tmo) begin errors++; $display("FAIL rand_terr[%0d]: got %b expected %b", k, timeout_err, m_tmo); end
            checks++; if (!$onehot0(bus_grant)) begin errors++; $display("FAIL rand_onehot[%0d]: got %b expected one-hot or 0000", k, bus_grant); end
            checks++; if (h2 != 4'b0000 && h1 == 4'b0000 && bus_grant != 4'b0000) begin errors++; $display("FAIL rand_gap[%0d]: got %b expected 0000 after release", k, bus_grant); end
            h2 = h1; h1 = bus_grant;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_hold_drop();
        test_reset_mid_grant();
        test_spurious_ack();
        test_no_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter sharing the single bus slave between N_REQ masters.
- Issues a one-hot grant from the arbitration package type (arb_vector, idle value NO_GRANT = all zeros).
- Holds the grant until the slave returns bus_ack, then forces one NO_GRANT cycle before the next grant.
- Sits between master request lines and the slave's bus_grant/bus_ack handshake.

Parameters:
- N_REQ, 4: number of requesters; must equal the arb_vector width.
- TIMEOUT_CYC, 16: watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- bus_req  input  N_REQ  request per master; bit i = master i.
- bus_ack  input  1  one-cycle completion pulse from the slave.
- bus_grant  output  arb_vector (N_REQ)  one-hot grant, registered; NO_GRANT when idle.
- grant_id  output  $clog2(N_REQ)  index of the granted master; valid while busy = 1.
- busy  output  1  high while any grant is outstanding.
- timeout_err  output  1  one-cycle pulse on watchdog expiry; constant 0 when the feature is disabled.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; bus_grant = NO_GRANT; grant_id = 0; busy = 0; timeout_err = 0.
  - last pointer = N_REQ-1, so master 0 has first priority.
- All outputs are registered. No combinational path from inputs to outputs.
- IDLE:
  - If bus_req != 0 at a clock edge, grant the first requester found by scanning upward from last+1, wrapping at N_REQ-1 -> 0.
  - At that same edge: bus_grant = one-hot(winner), grant_id = winner, busy = 1, last = winner, go to GRANT.
  - Latency: request sampled at edge t -> grant visible after edge t.
- GRANT:
  - Grant is held stable regardless of bus_req.
  - A requester dropping its request mid-transaction does not revoke the grant.
  - When bus_ack = 1 at an edge: bus_grant = NO_GRANT, busy = 0, go to GAP.
- GAP:
  - Exactly one cycle with bus_grant = NO_GRANT. The slave needs this to return to idle without re-triggering.
  - Always go to IDLE. Requests present during GAP are evaluated at the IDLE edge.
- bus_ack outside GRANT is ignored. No state change, no error.
- Simultaneous requests: the round-robin order alone decides the winner.
  - A master requesting continuously gets at most one grant per N_REQ grants while others request.
- Single requester: granted repeatedly, one transaction per 3 cycles minimum (IDLE, GRANT, GAP) plus the slave latency.
- bus_grant is always one-hot or NO_GRANT. Never multi-hot.
- Reset asserted mid-GRANT: grant is dropped immediately and the pointer returns to N_REQ-1. No transaction is resumed.
- State encoding: enum {IDLE, GRANT, GAP}. The default branch returns to IDLE with NO_GRANT.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to GRANT and incremented each cycle in GRANT.
  - If it reaches TIMEOUT_CYC-1 without bus_ack: bus_grant = NO_GRANT, busy = 0, timeout_err = 1 for one cycle, go to GAP.
  - The pointer keeps the timed-out master as last.
  - If bus_ack and expiry coincide, bus_ack wins and timeout_err stays 0.
- Undefined: no counter is built; timeout_err is tied to 0, and a grant is held indefinitely until bus_ack.

Test Plan:
- Reset, then bus_req = 4'b0010 -> bus_grant = 4'b0010 and grant_id = 1 one cycle later. Slave acks after BUSY1 -> grant NO_GRANT for exactly one cycle (GAP), busy = 0.
- bus_req = 4'b1111 held constant over 8 transactions -> grants in order 0,1,2,3,0,1,2,3, each separated by one NO_GRANT cycle.
- Master 2 granted with slave waitstate = 1 (ack two cycles later) and bus_req[2] deasserted during GRANT -> grant held until bus_ack, then released normally.
- Reset pulsed while bus_grant = 4'b0100 -> bus_grant = NO_GRANT immediately (asynchronously). Next request 4'b0101 -> master 0 granted first.
- Spurious bus_ack = 1 in IDLE with bus_req = 0 -> no output change. Random stress -> assertions: bus_grant never multi-hot; a grant is never issued in the cycle after bus_ack.
- ARB_TIMEOUT_EN defined, TIMEOUT_CYC = 16, bus_ack tied 0 -> grant drops after 16 GRANT cycles, timeout_err pulses 1 cycle, next requester granted after GAP.
